ps2_scancode: RTL and testbench

- Upstream front end for the Spectrum keyboard matrix mapper.
- Samples the raw PS/2 clock and data lines, filters them, and deserialises 11-bit device-to-host frames with start, parity and stop checks.
- Folds the E0 (extended) and F0 (break) prefixes into flags on each keycode.
- Queues decoded events in a 4-entry FIFO; the matrix stage pops them with a read strobe.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_fifo.sv | 74 +++++++
 rtl/ps2_scancode.sv | 183 ++++++++++++++++++
 tb/tb_ps2_scancode.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 scancode front end: prefix byte values,
// the Pause tail length, the frame FSM state type and the layout of a
// queued keyboard event.
//
// Event word layout (10 bits): [9] extended, [8] released, [7:0] code.

package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam int         PAUSE_TAIL = 7;

    localparam int Q_WIDTH   = 10;
    localparam int Q_EXT_BIT = 9;
    localparam int Q_BRK_BIT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo
// Small first-word-fall-through event queue between the PS/2 decoder and
// the keyboard matrix stage. Pointers carry one extra bit so full and empty
// can be told apart when the index bits match.
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-low reset
//   push     in   write wdata this cycle (dropped if full without rd)
//   wdata    in   event word
//   rd       in   pop the head entry (ignored while empty)
//   q        out  head entry, read combinationally from the array
//   empty    out  no entries held
//   overflow out  sticky, set when a push is dropped; cleared by reset
//
// Handshake: q is valid whenever empty=0; a pop happens on every clock
// edge where rd=1 and empty=0, and the next entry (if any) appears on q
// right after that edge.

module ps2_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             overflow
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                full;
    logic                do_pop;
    logic                do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop  = rd && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = push && (!full || do_pop);
    assign q       = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode.sv
// ps2_scancode
// PS/2 keyboard receiver: synchronises and filters the raw PS/2 clock,
// deserialises 11-bit device-to-host frames, folds E0/F0 prefixes into
// flags, swallows the Pause (E1) sequence and queues events in ps2_fifo.
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-low reset
//   ce       in   sample enable; receiver state moves only when ce=1
//   ps2[1:0] in   raw lines: [0] PS/2 clock, [1] PS/2 data
//   rd       in   pop strobe, honoured every clock regardless of ce
//   q[9:0]   out  head event {extended, released, code}
//   empty    out  no event queued
//   overflow out  sticky, an event was dropped on a full queue
//   err      out  one-clock pulse on a parity, stop or timeout error
//
// The frame FSM state is held in the enum register "state".

module ps2_scancode
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 2000,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce,
    input  logic [1:0]         ps2,
    input  logic               rd,
    output logic [Q_WIDTH-1:0] q,
    output logic               empty,
    output logic               overflow,
    output logic               err
);

    localparam int          TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [1:0]            sync_meta;
    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic [FILTER_LEN-1:0] sr_next;
    logic                  clk_f;
    logic                  fall;
    logic                  data_s;

    frame_state_t          state;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;
    logic                  par_acc;
    logic                  par_ok;
    logic [TW-1:0]         tcnt;

    logic                  extended;
    logic                  released;
    logic [2:0]            skip;
    logic                  accept;
    logic                  push;
    logic [Q_WIDTH-1:0]    push_data;

    assign data_s  = sync[1];
    assign sr_next = {filt_sr[FILTER_LEN-2:0], sync[0]};
    // Fall fires on the tick the filter first fills with zeros while the
    // filtered clock is still high.
    assign fall    = ce && clk_f && (sr_next == '0);
    assign accept  = fall && (state == STOP) && data_s && par_ok;
    assign push    = accept && (skip == 3'd0) && (shift != PS2_EXT) &&
                     (shift != PS2_BRK) && (shift != PS2_PAUSE);

    always_comb begin
        push_data            = {2'b00, shift};
        push_data[Q_EXT_BIT] = extended;
        push_data[Q_BRK_BIT] = released;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_meta <= 2'b11;
            sync      <= 2'b11;
            filt_sr   <= '1;
            clk_f     <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            par_acc   <= 1'b0;
            par_ok    <= 1'b0;
            tcnt      <= '0;
            err       <= 1'b0;
            extended  <= 1'b0;
            released  <= 1'b0;
            skip      <= 3'd0;
        end else begin
            err <= 1'b0;
            if (ce) begin
                sync_meta <= ps2;
                sync      <= sync_meta;
                filt_sr   <= sr_next;
                if (&sr_next) begin
                    clk_f <= 1'b1;
                end else if (~|sr_next) begin
                    clk_f <= 1'b0;
                end

                // Inter-edge watchdog; only the ticks without a fall count.
                if (state != IDLE && !fall) begin
                    if (tcnt == TMAX) begin
                        state <= IDLE;
                        err   <= 1'b1;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                if (fall) begin
                    tcnt <= '0;
                    case (state)
                        IDLE: begin
                            if (!data_s) begin
                                state   <= DATA;
                                bit_cnt <= 3'd0;
                                par_acc <= 1'b0;
                            end
                        end
                        DATA: begin
                            shift   <= {data_s, shift[7:1]};
                            par_acc <= par_acc ^ data_s;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= PARITY;
                            end
                        end
                        PARITY: begin
                            par_ok <= par_acc ^ data_s;
                            state  <= STOP;
                        end
                        STOP: begin
                            if (!(data_s && par_ok)) begin
                                err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end

                // Prefix folding happens on the acceptance tick itself.
                if (accept) begin
                    if (skip != 3'd0) begin
                        skip <= skip - 3'd1;
                    end else if (shift == PS2_EXT) begin
                        extended <= 1'b1;
                    end else if (shift == PS2_BRK) begin
                        released <= 1'b1;
                    end else if (shift == PS2_PAUSE) begin
                        skip     <= 3'(PAUSE_TAIL);
                        extended <= 1'b0;
                        released <= 1'b0;
                    end else begin
                        extended <= 1'b0;
                        released <= 1'b0;
                    end
                end
            end
        end
    end

    ps2_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (Q_WIDTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .wdata    (push_data),
        .rd       (rd),
        .q        (q),
        .empty    (empty),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_ps2_scancode.sv
// tb_ps2_scancode
// Directed bench for ps2_scancode: bit-bangs PS/2 frames on the raw lines,
// queues the event words it expects in exp_q and compares them as the
// queue is drained through rd.

module tb_ps2_scancode;
    import ps2_pkg::*;

    localparam int HALF    = 12;
    localparam int TIMEOUT = 2000;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         ce    = 1'b1;
    logic         rd    = 1'b0;
    logic [1:0]   ps2   = 2'b11;
    logic [9:0]   q;
    logic         empty;
    logic         overflow;
    logic         err;

    logic [9:0]   exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           err_seen = 0;
    int           sync_pop_seen = 0;
    int           base;

    ps2_scancode #(
        .FILTER_LEN (8),
        .TIMEOUT    (TIMEOUT),
        .DEPTH_LOG2 (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .ps2      (ps2),
        .rd       (rd),
        .q        (q),
        .empty    (empty),
        .overflow (overflow),
        .err      (err)
    );

    // clock / reset block
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (err === 1'b1) err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500us");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, input bit sync_pop);
        @(negedge clock);
        ps2[1] = b;
        ps2[0] = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2[0] = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clock);
            rd = 1'b0;
            if (sync_pop && dut.push === 1'b1) begin
                check("sync_pop_head", q, exp_q.pop_front());
                rd = 1'b1;
                sync_pop_seen++;
            end
        end
        @(negedge clock);
        rd = 1'b0;
        ps2[0] = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit sync_pop);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(par, 1'b0);
        send_bit(1'b1, sync_pop);
        ps2 = 2'b11;
        idle(2 * HALF);
    endtask

    // scoreboard pop: wait (bounded) for data, compare head, strobe rd once
    task automatic pop_check(input string tag);
        int n;
        n = 0;
        while (empty !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_nonempty"}, 10'(empty), 10'd0);
        if (empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected"}, q, 10'h3FF ^ q);
            end else begin
                check(tag, q, exp_q.pop_front());
            end
            rd = 1'b1;
            @(negedge clock);
            rd = 1'b0;
            @(negedge clock);
        end
    endtask

    initial begin
        logic [7:0] six [6];
        logic [7:0] pause_seq [9];
        six = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h45};
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h5A};

        // reset state
        idle(3);
        check("reset_q", q, 10'h000);
        check("reset_empty", 10'(empty), 10'd1);
        check("reset_overflow", 10'(overflow), 10'd0);
        check("reset_err", 10'(err), 10'd0);
        reset = 1'b1;
        idle(5);

        // single good frame
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 1'b0);
        pop_check("frame_1c");
        check("empty_after_pop", 10'(empty), 10'd1);
        check("no_err_good_frame", 10'(err_seen), 10'd0);

        // extended break prefix folding
        exp_q.push_back(10'h375);
        send_frame(8'hE0, 1'b0, 1'b0);
        check("e0_not_queued", 10'(empty), 10'd1);
        send_frame(8'hF0, 1'b0, 1'b0);
        check("f0_not_queued", 10'(empty), 10'd1);
        send_frame(8'h75, 1'b0, 1'b0);
        pop_check("ext_brk_75");
        check("single_entry_ext", 10'(empty), 10'd1);

        // parity error, then recovery
        base = err_seen;
        send_frame(8'h1A, 1'b1, 1'b0);
        check("parity_err_pulse", 10'(err_seen - base), 10'd1);
        check("parity_err_empty", 10'(empty), 10'd1);
        exp_q.push_back(10'h022);
        send_frame(8'h22, 1'b0, 1'b0);
        pop_check("after_parity_22");

        // timeout after 5 data bits
        base = err_seen;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        ps2 = 2'b11;
        idle(TIMEOUT + 50);
        check("timeout_err_pulse", 10'(err_seen - base), 10'd1);
        check("timeout_fsm_idle", 10'(dut.state), 10'(IDLE));
        check("timeout_empty", 10'(empty), 10'd1);
        exp_q.push_back(10'h029);
        send_frame(8'h29, 1'b0, 1'b0);
        pop_check("after_timeout_29");

        // overflow: six frames into a four-entry queue
        for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, six[i]});
        for (int i = 0; i < 6; i++) send_frame(six[i], 1'b0, 1'b0);
        check("overflow_set", 10'(overflow), 10'd1);
        check("overflow_head", q, 10'h016);
        // frame arriving together with a pop while full is kept
        exp_q.push_back(10'h036);
        send_frame(8'h36, 1'b0, 1'b1);
        check("sync_pop_seen", 10'(sync_pop_seen), 10'd1);
        check("overflow_sticky", 10'(overflow), 10'd1);
        pop_check("drain_1e");
        pop_check("drain_26");
        pop_check("drain_25");
        pop_check("drain_36");
        check("drain_empty", 10'(empty), 10'd1);
        check("overflow_still_set", 10'(overflow), 10'd1);

        // reset in the middle of a frame
        base = err_seen;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        ps2 = 2'b11;
        reset = 1'b0;
        idle(2);
        check("midreset_overflow", 10'(overflow), 10'd0);
        check("midreset_empty", 10'(empty), 10'd1);
        check("midreset_fsm_idle", 10'(dut.state), 10'(IDLE));
        reset = 1'b1;
        idle(20);
        check("midreset_no_err", 10'(err_seen - base), 10'd0);

        // Pause sequence swallowed, 5A kept
        exp_q.push_back(10'h05A);
        foreach (pause_seq[i]) send_frame(pause_seq[i], 1'b0, 1'b0);
        pop_check("pause_then_5a");
        check("pause_only_one", 10'(empty), 10'd1);

        // two-clock glitch on the PS/2 clock with data low
        base = err_seen;
        ps2 = 2'b01;
        idle(HALF);
        ps2 = 2'b00;
        idle(2);
        ps2 = 2'b01;
        idle(HALF);
        ps2 = 2'b11;
        idle(40);
        check("glitch_fsm_idle", 10'(dut.state), 10'(IDLE));
        check("glitch_no_err", 10'(err_seen - base), 10'd0);
        exp_q.push_back(10'h066);
        send_frame(8'h66, 1'b0, 1'b0);
        pop_check("after_glitch_66");

        check("total_err_pulses", 10'(err_seen), 10'd2);
        check("scoreboard_drained", 10'(exp_q.size()), 10'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
